// File: rtl/fir_direct_nominal.sv
// Direct-form FIR: NUM_TAPS runtime coefficients, full-precision sum, floor scaling, saturation.
// Latency: 1 cycle from the sample on `in` at edge n to y[n] on `out` after that edge.
// Backpressure: none; one sample is accepted every clock and the block never stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset; clears the delay line and the output
//   in         signed input sample x[n] (DATA_WIDTH)
//   tap_coeffs signed coefficients c[k], Q1.(TAP_COEFF_WIDTH-1); used combinationally
//   out        signed, saturated, registered filter output y[n] (DATA_WIDTH)
module fir_direct_nominal #(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [DATA_WIDTH-1:0]      in,
    input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
    output logic signed [DATA_WIDTH-1:0]      out
);

    // Product and accumulator widths. The accumulator carries enough guard
    // bits for NUM_TAPS worst-case products, so the sum cannot overflow.
    localparam int PW = DATA_WIDTH + TAP_COEFF_WIDTH;
    localparam int SW = PW + $clog2(NUM_TAPS);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [SW-1:0] Q_MAX =
        {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] Q_MIN =
        {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Delay line d[1..NUM_TAPS-1]; tap 0 is the live input.
    logic signed [DATA_WIDTH-1:0] r_dly [1:NUM_TAPS-1];
    logic signed [DATA_WIDTH-1:0] r_out;

    logic signed [DATA_WIDTH-1:0] w_tap  [NUM_TAPS];
    logic signed [PW-1:0]         w_prod [NUM_TAPS];
    logic signed [SW-1:0]         w_prod_ext [NUM_TAPS];
    logic signed [SW-1:0]         w_sum;
    logic signed [SW-1:0]         w_q;
    logic signed [DATA_WIDTH-1:0] w_sat;

    assign w_tap[0] = in;

    genvar g;
    generate
        for (g = 1; g < NUM_TAPS; g++) begin : g_tap
            assign w_tap[g] = r_dly[g];
        end

        for (g = 0; g < NUM_TAPS; g++) begin : g_mult
            logic signed [PW-1:0] w_a;
            logic signed [PW-1:0] w_b;
            // Explicit sign extension so the multiply is carried out at
            // full product width with no reliance on context sizing.
            assign w_a = {{TAP_COEFF_WIDTH{w_tap[g][DATA_WIDTH-1]}}, w_tap[g]};
            assign w_b = {{DATA_WIDTH{tap_coeffs[g][TAP_COEFF_WIDTH-1]}}, tap_coeffs[g]};
            assign w_prod[g] = w_a * w_b;
            assign w_prod_ext[g] = {{(SW-PW){w_prod[g][PW-1]}}, w_prod[g]};
        end
    endgenerate

    // Plain adder chain; this is the unpipelined reference datapath.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_sum = w_sum + w_prod_ext[k];
        end
    end

    // Arithmetic shift drops the fractional coefficient bits with floor rounding.
    assign w_q = w_sum >>> (TAP_COEFF_WIDTH - 1);

    always_comb begin
        w_sat = w_q[DATA_WIDTH-1:0];
        if (w_q > Q_MAX) begin
            w_sat = Q_MAX[DATA_WIDTH-1:0];
        end else if (w_q < Q_MIN) begin
            w_sat = Q_MIN[DATA_WIDTH-1:0];
        end
    end

    // Reset wins over the shift; the sample present during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k < NUM_TAPS; k++) begin
                r_dly[k] <= '0;
            end
            r_out <= '0;
        end else begin
            r_dly[1] <= in;
            for (int k = 2; k < NUM_TAPS; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            r_out <= w_sat;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_fir_direct_nominal.sv
module tb_fir_direct_nominal;

    localparam int DW = 5;
    localparam int CW = 5;
    localparam int NT = 50;

    logic                 clk;
    logic                 tb_rst;
    logic signed [DW-1:0] tb_in;
    logic signed [CW-1:0] tb_c [NT];
    logic signed [DW-1:0] tb_out;

    int n_checks;
    int n_pass;

    // Reference model state: inputs seen since the last reset, newest first.
    int hist [NT];
    int exp_y;

    fir_direct_nominal #(
        .DATA_WIDTH     (DW),
        .TAP_COEFF_WIDTH(CW),
        .NUM_TAPS       (NT)
    ) dut (
        .clk       (clk),
        .rst       (tb_rst),
        .in        (tb_in),
        .tap_coeffs(tb_c),
        .out       (tb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // y = sat(floor(sum c[k]*x[n-k] / 16)), written with plain integers.
    task automatic model_edge(input int x, input logic r);
        int s;
        int q;
        if (!r) begin
            for (int k = 0; k < NT; k++) hist[k] = 0;
            exp_y = 0;
        end else begin
            for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            s = 0;
            for (int k = 0; k < NT; k++) s += hist[k] * int'(tb_c[k]);
            q = s >>> (CW - 1);
            if (q > 15) q = 15;
            if (q < -16) q = -16;
            exp_y = q;
        end
    endtask

    // Drive one sample, clock it in, then compare against the model on the falling edge.
    task automatic step(input string tag, input logic signed [DW-1:0] x, input logic r);
        tb_in  = x;
        tb_rst = r;
        @(posedge clk);
        model_edge(int'(x), r);
        @(negedge clk);
        check(tag, $signed(tb_out), exp_y);
    endtask

    task automatic set_coeffs(input int v, input int ntaps);
        for (int k = 0; k < NT; k++) tb_c[k] = (k < ntaps) ? CW'(v) : '0;
    endtask

    initial begin
        int imp_exp [6];
        int ramp_exp [5];
        logic signed [DW-1:0] v;

        n_checks = 0;
        n_pass   = 0;
        tb_rst   = 1'b0;
        tb_in    = '0;
        for (int k = 0; k < NT; k++) begin
            hist[k] = 0;
            tb_c[k] = CW'($urandom);
        end
        exp_y = 0;

        // Reset with a non-zero input, then silence.
        step("reset0", 5'sd7, 1'b0);
        step("reset1", 5'sd7, 1'b0);
        check("reset_out", $signed(tb_out), 0);
        for (int i = 0; i < 50; i++) step("idle", 5'sd0, 1'b1);
        check("idle_out", $signed(tb_out), 0);

        // Impulse response.
        set_coeffs(3, 4);
        step("imp_rst", 5'sd0, 1'b0);
        imp_exp = '{2, 2, 2, 2, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step("imp", (i == 0) ? 5'sd15 : 5'sd0, 1'b1);
            check("imp_lit", $signed(tb_out), imp_exp[i]);
        end

        // Positive step.
        step("stp_rst", 5'sd0, 1'b0);
        ramp_exp = '{2, 5, 8, 11, 11};
        for (int i = 0; i < 5; i++) begin
            step("stp", 5'sd15, 1'b1);
            check("stp_lit", $signed(tb_out), ramp_exp[i]);
        end

        // Reset in the middle of the step: history must be gone.
        step("mid_rst", 5'sd15, 1'b0);
        check("mid_rst_lit", $signed(tb_out), 0);
        for (int i = 0; i < 5; i++) begin
            step("mid", 5'sd15, 1'b1);
            check("mid_lit", $signed(tb_out), ramp_exp[i]);
        end

        // Negative step, floor rounding toward -inf.
        step("neg_rst", 5'sd0, 1'b0);
        ramp_exp = '{-3, -6, -9, -12, -12};
        for (int i = 0; i < 5; i++) begin
            step("neg", -5'sd16, 1'b1);
            check("neg_lit", $signed(tb_out), ramp_exp[i]);
        end

        // Saturation at both rails.
        set_coeffs(15, NT);
        step("sat_rst", 5'sd0, 1'b0);
        for (int i = 0; i < 55; i++) step("satp", 5'sd15, 1'b1);
        check("satp_lit", $signed(tb_out), 15);
        for (int i = 0; i < 55; i++) step("satn", -5'sd16, 1'b1);
        check("satn_lit", $signed(tb_out), -16);

        // Ramp with two's-complement wrap.
        set_coeffs(3, 4);
        step("ramp_rst", 5'sd0, 1'b0);
        v = -5'sd1;
        for (int i = 0; i < 110; i++) begin
            step("ramp", v, 1'b1);
            v = v + 5'sd1;
        end

        // Random coefficients, inputs and occasional resets; coefficients
        // are also changed on the fly to exercise the combinational use.
        for (int k = 0; k < NT; k++) tb_c[k] = CW'($urandom);
        step("rnd_rst", 5'sd0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) tb_c[$urandom_range(0, NT-1)] = CW'($urandom);
            step("rnd", DW'($urandom), ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
